// File: rtl/alu_64_bit.sv
// alu_64_bit: registered integer ALU for the execute stage.
//   Combines a and b under the 4-bit ALU_CO code. Result, zero and overflow
//   are registered, so each op appears exactly one cycle after it is
//   presented. A new op may be issued every cycle; there is no handshake.
// Ports:
//   ALU_result  out WIDTH  registered result
//   zero        out 1      registered, 1 when ALU_result == 0
//   overflow    out 1      registered signed overflow (ADD/SUB only)
//   ALU_CO      in  4      operation code
//   a, b        in  WIDTH  operands
//   clk         in  1      clock, rising edge
//   reset       in  1      synchronous, active-high
// Config macro: ALU_SHIFT_EN builds SLL/SRL/SRA (codes 0100/0101/1000).
//   Without it those codes fall into the undefined-code path (result 0).
module alu_64_bit #(
  parameter int WIDTH = 64
) (
  output logic [WIDTH-1:0] ALU_result,
  output logic             zero,
  output logic             overflow,
  input  logic [3:0]       ALU_CO,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             reset
);
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
`ifdef ALU_SHIFT_EN
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SRL = 4'b0101;
  localparam logic [3:0] OP_SRA = 4'b1000;
  localparam int         SHW    = $clog2(WIDTH);
`endif

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             ovf;
  } alu_rsp_t;

  logic [WIDTH-1:0] sum, dif;
  logic             slt;
  alu_rsp_t         nxt;

  assign sum = a + b;
  assign dif = a - b;
  assign slt = $signed(a) < $signed(b);

  always_comb begin
    nxt = '0;
    unique case (ALU_CO)
      OP_AND: nxt.res = a & b;
      OP_OR:  nxt.res = a | b;
      OP_XOR: nxt.res = a ^ b;
      OP_NOR: nxt.res = ~(a | b);
      OP_SLT: nxt.res = {{(WIDTH-1){1'b0}}, slt};
      OP_ADD: begin
        nxt.res = sum;
        // same-sign operands producing an opposite-sign result
        nxt.ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        nxt.res = dif;
        nxt.ovf = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
      end
`ifdef ALU_SHIFT_EN
      // only the low log2(WIDTH) bits of b select the shift distance
      OP_SLL: nxt.res = a << b[SHW-1:0];
      OP_SRL: nxt.res = a >> b[SHW-1:0];
      OP_SRA: nxt.res = WIDTH'($signed(a) >>> b[SHW-1:0]);
`endif
      default: nxt = '0;
    endcase
  end

  // zero comes from the same next-state value so it always tracks ALU_result
  always_ff @(posedge clk) begin
    if (reset) begin
      ALU_result <= '0;
      zero       <= 1'b1;
      overflow   <= 1'b0;
    end else begin
      ALU_result <= nxt.res;
      zero       <= (nxt.res == '0);
      overflow   <= nxt.ovf;
    end
  end
endmodule

// File: tb/tb_alu_64_bit.sv
module tb_alu_64_bit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  ALU_CO = 4'b0;
  logic [63:0] a = '0, b = '0;
  logic [63:0] ALU_result;
  logic        zero, overflow;

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic        o;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   passed = 0;
  int   total  = 0;

  alu_64_bit #(.WIDTH(64)) dut (
    .ALU_result(ALU_result), .zero(zero), .overflow(overflow),
    .ALU_CO(ALU_CO), .a(a), .b(b), .clk(clk), .reset(reset)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [63:0] r, input logic o);
    exp_t t;
    t.res = r; t.z = (r == 64'd0); t.o = o;
    return t;
  endfunction

  // reference model, written from the operation definitions
  function automatic exp_t model(input logic [3:0] op, input logic [63:0] x, y, input logic rst);
    logic signed [64:0] w;
    logic [63:0] r;
    logic o;
    r = '0; o = 1'b0;
    if (rst) return mk(64'd0, 1'b0);
    case (op)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b0011: r = x ^ y;
      4'b1100: r = ~(x | y);
      4'b0111: r = ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
      4'b0010: begin w = $signed({x[63], x}) + $signed({y[63], y}); r = w[63:0]; o = w[64] ^ w[63]; end
      4'b0110: begin w = $signed({x[63], x}) - $signed({y[63], y}); r = w[63:0]; o = w[64] ^ w[63]; end
`ifdef ALU_SHIFT_EN
      4'b0100: begin r = x; repeat (int'(y[5:0])) r = {r[62:0], 1'b0}; end
      4'b0101: begin r = x; repeat (int'(y[5:0])) r = {1'b0, r[63:1]}; end
      4'b1000: begin r = x; repeat (int'(y[5:0])) r = {r[63], r[63:1]}; end
`endif
      default: r = '0;
    endcase
    return mk(r, o);
  endfunction

  // drive one op, record its expectation, advance to just after the capturing edge
  task automatic step(input logic [3:0] op, input logic [63:0] x, y, input logic rst, input exp_t ex);
    ALU_CO = op; a = x; b = y; reset = rst;
    sb.push_back(ex);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    step(4'b0010, 64'd7, 64'd9, 1'b1, mk(64'd0, 1'b0));
    e = sb.pop_front(); total++;
    if ({ALU_result, zero, overflow} !== {e.res, e.z, e.o})
      $display("FAIL reset: got res=%h z=%b o=%b want res=%h z=%b o=%b", ALU_result, zero, overflow, e.res, e.z, e.o);
    else passed++;
  endtask

  task automatic test_arith();
    logic [3:0]  op [6] = '{4'b0010, 4'b0110, 4'b0110, 4'b0010, 4'b0110, 4'b0010};
    logic [63:0] xa [6] = '{64'd1, 64'd1, 64'd5, 64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] xb [6] = '{64'd3, 64'd3, 64'd5, 64'd1, 64'd1, 64'd1};
    logic [63:0] xr [6] = '{64'd4, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0};
    logic        xo [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      step(op[i], xa[i], xb[i], 1'b0, mk(xr[i], xo[i]));
      e = sb.pop_front(); total++;
      if ({ALU_result, zero, overflow} !== {e.res, e.z, e.o})
        $display("FAIL arith[%0d]: got res=%h z=%b o=%b want res=%h z=%b o=%b", i, ALU_result, zero, overflow, e.res, e.z, e.o);
      else passed++;
    end
  endtask

  task automatic test_logic();
    logic [3:0]  op [7] = '{4'b0111, 4'b0111, 4'b1100, 4'b1111, 4'b0000, 4'b0001, 4'b0011};
    logic [63:0] xa [7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'hDEAD, 64'hF0F0, 64'hF0F0, 64'hFFFF};
    logic [63:0] xb [7] = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'hBEEF, 64'h0FF0, 64'h0F0F, 64'hFFFF};
    logic [63:0] xr [7] = '{64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h00F0, 64'hFFFF, 64'd0};
    for (int i = 0; i < 7; i++) begin
      step(op[i], xa[i], xb[i], 1'b0, mk(xr[i], 1'b0));
      e = sb.pop_front(); total++;
      if ({ALU_result, zero, overflow} !== {e.res, e.z, e.o})
        $display("FAIL logic[%0d]: got res=%h z=%b o=%b want res=%h z=%b o=%b", i, ALU_result, zero, overflow, e.res, e.z, e.o);
      else passed++;
    end
  endtask

  task automatic test_shift();
    logic [3:0]  op [4] = '{4'b1000, 4'b0101, 4'b0100, 4'b1000};
    logic [63:0] xb [4] = '{64'd65, 64'd65, 64'd65, 64'd64};
`ifdef ALU_SHIFT_EN
    logic [63:0] xr [4] = '{64'hC000_0000_0000_0000, 64'h4000_0000_0000_0000, 64'd0, 64'h8000_0000_0000_0000};
`else
    logic [63:0] xr [4] = '{64'd0, 64'd0, 64'd0, 64'd0};
`endif
    for (int i = 0; i < 4; i++) begin
      step(op[i], 64'h8000_0000_0000_0000, xb[i], 1'b0, mk(xr[i], 1'b0));
      e = sb.pop_front(); total++;
      if ({ALU_result, zero, overflow} !== {e.res, e.z, e.o})
        $display("FAIL shift[%0d]: got res=%h z=%b o=%b want res=%h z=%b o=%b", i, ALU_result, zero, overflow, e.res, e.z, e.o);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [3:0]  op;
    logic [63:0] x, y;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      x  = {$urandom, $urandom};
      y  = (i % 4 == 0) ? x : {$urandom, $urandom};
      step(op, x, y, 1'b0, model(op, x, y, 1'b0));
      e = sb.pop_front(); total++;
      if ({ALU_result, zero, overflow} !== {e.res, e.z, e.o})
        $display("FAIL random[%0d] op=%b: got res=%h z=%b o=%b want res=%h z=%b o=%b", i, op, ALU_result, zero, overflow, e.res, e.z, e.o);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] x, y;
    logic        r;
    for (int i = 0; i < 6; i++) begin
      x = {$urandom, $urandom} | 64'd1;
      y = {$urandom, $urandom};
      r = (i == 2);
      step(4'b0010, x, y, r, model(4'b0010, x, y, r));
      e = sb.pop_front(); total++;
      if ({ALU_result, zero, overflow} !== {e.res, e.z, e.o})
        $display("FAIL b2b[%0d]: got res=%h z=%b o=%b want res=%h z=%b o=%b", i, ALU_result, zero, overflow, e.res, e.z, e.o);
      else passed++;
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_random();
    test_back_to_back();
    test_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
